// File: rtl/clb_config_loader.sv
// clb_config_loader
//
// Loads serial configuration data into a bank of NUM_CLB logic blocks.
// A start request begins a sequence that, for each CLB in turn, shifts
// CFG_W bits (MSB first) off a valid/ready serial stream, presents the
// assembled word on bits_o, pulses that CLB's write strobe for one cycle,
// then holds the word one more cycle so the CLB samples a stable value on
// the edge after its strobe. done_o pulses once after the last CLB.
//
// Ports
//   clk_i        sole clock, all state changes on posedge
//   rst_i        synchronous active-high reset
//   start_i      one-cycle load request, honoured only when idle
//   cfg_valid_i  serial bit present on cfg_data_i
//   cfg_data_i   serial configuration bit, MSB of each word first
//   cfg_ready_o  loader accepts a bit this cycle (high only while shifting)
//   bits_o       configuration word broadcast to every CLB
//   wr_en_o      one-hot write strobe, bit k drives CLB k
//   busy_o       sequence in progress
//   done_o       one-cycle pulse after the last CLB is written
//
// State   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start_i
// S_SHIFT | accepting serial bits for the current CLB
// S_WRITE | strobing wr_en_o for the current CLB, word stable
// S_HOLD  | word held one extra cycle, no strobe
// S_DONE  | done_o pulse, then back to idle

module clb_config_loader #(
  parameter int NUM_CLB = 4,
  parameter int CFG_W   = 23
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               cfg_valid_i,
  input  logic               cfg_data_i,
  output logic               cfg_ready_o,
  output logic [CFG_W-1:0]   bits_o,
  output logic [NUM_CLB-1:0] wr_en_o,
  output logic               busy_o,
  output logic               done_o
);

  // A single CLB still gets a 1-bit index so the register is never zero width.
  localparam int IDX_W = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;
  localparam int CNT_W = $clog2(CFG_W + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLB - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CFG_W-1:0] shift_q;
  logic [CFG_W-1:0] shift_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;
  logic [IDX_W-1:0] clb_idx_q;
  logic [IDX_W-1:0] clb_idx_d;
  logic             xfer;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clb_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clb_idx_q <= clb_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    clb_idx_d   = clb_idx_q;
    cfg_ready_o = 1'b0;
    wr_en_o     = '0;
    done_o      = 1'b0;
    xfer        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          clb_idx_d = '0;
        end
      end

      S_SHIFT: begin
        cfg_ready_o = 1'b1;
        xfer        = cfg_valid_i;
        if (xfer) begin
          // Left shift written as shift/or so it holds for any CFG_W.
          shift_d = (shift_q << 1) | CFG_W'(cfg_data_i);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = S_WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      S_WRITE: begin
        for (int k = 0; k < NUM_CLB; k++) begin
          wr_en_o[k] = (clb_idx_q == IDX_W'(k));
        end
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (clb_idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          clb_idx_d = clb_idx_q + IDX_W'(1);
          state_d   = S_SHIFT;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign bits_o = shift_q;

endmodule
